uart_tx_scheduler: RTL and testbench
====================================

Name: uart_tx_scheduler

Overview:
Shares one UART transmitter (and its baud-rate generator select) among N_REQ requesters using round-robin arbitration. It latches the winner's byte and baud select, and reprograms sel only between frames, waiting a settle time after any change. It then pulses the transmitter load, tracks txd_busy to frame completion, and enforces an inter-frame idle gap. It sits between client logic and the transmitter/brg pair.

Parameters:
N_REQ, 4, number of requesters (2..8); IDW = clog2(N_REQ)
SETTLE_CYCLES, 8, sysclk cycles held in CFG after sel changes (min 1)
GAP_CYCLES, 16, sysclk idle cycles after a frame before next arbitration (0 allowed)
BUSY_TO, 64, max sysclk cycles from tdr_load to txd_busy rising before abort

Ports:
sysclk  in  1  system clock; all logic on rising edge
rst  in  1  synchronous, active-high reset
req  in  N_REQ  per-requester request level
req_data  in  8*N_REQ  byte for requester i at [8i+7:8i]
req_sel  in  3*N_REQ  baud select for requester i at [3i+2:3i]
gnt  out  N_REQ  one-hot, 1-cycle pulse: request accepted, data latched
done  out  N_REQ  one-hot, 1-cycle pulse: that requester's frame finished or aborted
err  out  1  1-cycle pulse coincident with done on timeout abort
TDR  out  8  byte to transmitter, stable from LOAD until next grant
tdr_load  out  1  1-cycle load strobe to transmitter
sel  out  3  baud select to brg
txd_busy  in  1  transmitter busy (high while shifting a frame)
owner  out  IDW  index of current/last granted requester
arb_busy  out  1  high in every state except IDLE

Behaviour:
- Reset (rst=1 on a sysclk edge): state=IDLE; gnt=0, done=0, err=0, tdr_load=0, TDR=8'h00, sel=3'd0, owner=N_REQ-1, arb_busy=0, counters=0. Reset mid-frame abandons it: no done, no err.
- FSM states: IDLE, CFG, LOAD, WAIT_BUSY, WAIT_DONE, GAP.
- IDLE: if req!=0, winner = first set bit searching owner+1, owner+2, ... modulo N_REQ. Next cycle: gnt[winner]=1, owner=winner, TDR=req_data[winner], pending_sel=req_sel[winner], then go to CFG. If req==0, stay in IDLE.
- Grant latency: req seen in IDLE at edge t -> gnt high during cycle t+1. A requester still holding req after gnt is treated as a new request and is arbitrated again after GAP.
- CFG: if pending_sel==sel, go to LOAD next cycle. Otherwise sel<=pending_sel and hold SETTLE_CYCLES cycles, then go to LOAD. sel never changes outside CFG.
- LOAD: tdr_load=1 for exactly one cycle; clear to counter; go to WAIT_BUSY.
- WAIT_BUSY: txd_busy=1 -> WAIT_DONE. If the counter reaches BUSY_TO first, pulse done[owner] and err, then go to GAP.
- WAIT_DONE: txd_busy=0 -> pulse done[owner] (err=0), go to GAP. No timeout in this state.
- GAP: count GAP_CYCLES, then go to IDLE. If GAP_CYCLES=0, go straight to IDLE on the next cycle.
- Round-robin: owner updates only at grant. No requester waits more than N_REQ-1 frames while holding req.
- Requests arriving outside IDLE are ignored until IDLE; req_data and req_sel are sampled only at the IDLE decision edge.
- Simultaneous requests: only one gnt per arbitration cycle.
- Throughput: at most one frame in flight; TDR held constant from grant until the next grant.

Test Plan:
1. Single request: req=4'b0001, data0=8'hA5, sel0=0, sel already 0 -> gnt[0] one cycle after req; tdr_load 2 cycles after gnt with no settle; TDR=8'hA5; done[0] one cycle after txd_busy falls; then arb_busy low GAP_CYCLES+1 cycles after done.
2. Round-robin: req=4'b1111 held with distinct bytes 8'h10..8'h13 -> grant order 0,1,2,3,0; every gnt is one-hot; TDR sequence matches.
3. Sel change: ch1 sel=3, ch2 sel=3, ch3 sel=5 -> sel changes to 3 then 5 only in CFG; each change is followed by exactly SETTLE_CYCLES before tdr_load; same-sel frame loads without settle; sel stable while txd_busy=1.
4. Timeout: keep txd_busy=0 after tdr_load -> done[owner] and err pulse together exactly BUSY_TO cycles after WAIT_BUSY entry; next arbitration follows the gap.
5. Reset mid-frame: assert rst during WAIT_DONE -> next cycle all outputs reset, owner=N_REQ-1, no done; after release, req=4'b0110 grants ch1 first.
6. Late request: raise req[2] during WAIT_DONE of ch0 -> no gnt before GAP completes; gnt[2] first cycle after IDLE decision.

Source files
------------

// File: rtl/uart_tx_scheduler.sv
// uart_tx_scheduler: round-robin sharing of one UART transmitter and its baud select among N_REQ clients
// Ports: sysclk/rst (sync, active-high); req/req_data/req_sel client requests with per-client byte and baud select;
// gnt/done one-hot pulses per client; err marks a busy-timeout abort; TDR/tdr_load feed the transmitter;
// sel drives the baud generator; txd_busy is transmitter status; owner is the last grantee; arb_busy is high outside IDLE.
module uart_tx_scheduler #(
    parameter int N_REQ = 4,
    parameter int SETTLE_CYCLES = 8,
    parameter int GAP_CYCLES = 16,
    parameter int BUSY_TO = 64,
    localparam int IDW = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic               sysclk,
    input  logic               rst,
    input  logic [N_REQ-1:0]   req,
    input  logic [8*N_REQ-1:0] req_data,
    input  logic [3*N_REQ-1:0] req_sel,
    output logic [N_REQ-1:0]   gnt,
    output logic [N_REQ-1:0]   done,
    output logic               err,
    output logic [7:0]         TDR,
    output logic               tdr_load,
    output logic [2:0]         sel,
    input  logic               txd_busy,
    output logic [IDW-1:0]     owner,
    output logic               arb_busy
);
    localparam int CW = $clog2(BUSY_TO + GAP_CYCLES + SETTLE_CYCLES + 1);
    typedef enum logic [2:0] {IDLE, CFG, LOAD, WAIT_BUSY, WAIT_DONE, GAP} state_t;
    state_t state;
    logic [CW-1:0] cnt;
    logic [2:0] pending_sel;
    logic [IDW-1:0] win;
    int idx;
    // Scan downward so the nearest set bit after owner is the last one written.
    always_comb begin
        win = owner;
        idx = 0;
        for (int k = N_REQ; k >= 1; k--) begin
            idx = (int'(owner) + k) % N_REQ;
            if (req[idx]) win = IDW'(idx);
        end
    end
    assign arb_busy = state != IDLE;
    always_ff @(posedge sysclk) begin
        if (rst) begin
            state <= IDLE;
            gnt <= '0;
            done <= '0;
            err <= 1'b0;
            tdr_load <= 1'b0;
            TDR <= 8'h00;
            sel <= 3'd0;
            owner <= IDW'(N_REQ - 1);
            cnt <= '0;
            pending_sel <= 3'd0;
        end else begin
            gnt <= '0;
            done <= '0;
            err <= 1'b0;
            tdr_load <= 1'b0;
            case (state)
                IDLE: if (|req) begin
                    gnt <= N_REQ'(1) << win;
                    owner <= win;
                    TDR <= req_data[8*win +: 8];
                    pending_sel <= req_sel[3*win +: 3];
                    cnt <= '0;
                    state <= CFG;
                end
                // A nonzero cnt here means sel was just reprogrammed and is settling.
                CFG: if (cnt != '0) begin
                    cnt <= cnt - 1'b1;
                    if (cnt == CW'(1)) state <= LOAD;
                end else if (pending_sel != sel) begin
                    sel <= pending_sel;
                    cnt <= CW'(SETTLE_CYCLES);
                end else begin
                    state <= LOAD;
                end
                LOAD: begin
                    tdr_load <= 1'b1;
                    cnt <= '0;
                    state <= WAIT_BUSY;
                end
                WAIT_BUSY: if (txd_busy) begin
                    state <= WAIT_DONE;
                end else if (cnt == CW'(BUSY_TO - 1)) begin
                    done <= N_REQ'(1) << owner;
                    err <= 1'b1;
                    cnt <= '0;
                    state <= GAP;
                end else begin
                    cnt <= cnt + 1'b1;
                end
                WAIT_DONE: if (!txd_busy) begin
                    done <= N_REQ'(1) << owner;
                    cnt <= '0;
                    state <= GAP;
                end
                GAP: if (cnt == CW'(GAP_CYCLES)) state <= IDLE;
                     else cnt <= cnt + 1'b1;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_uart_tx_scheduler.sv
// tb_uart_tx_scheduler: directed and random frames checked against a round-robin transaction model
module tb_uart_tx_scheduler;
    localparam int N = 4;
    localparam int S = 3;
    localparam int G = 5;
    localparam int B = 20;
    logic sysclk = 1'b0;
    logic rst = 1'b1;
    logic [N-1:0] req = '0;
    logic [8*N-1:0] req_data = '0;
    logic [3*N-1:0] req_sel = '0;
    logic txd_busy = 1'b0;
    logic [N-1:0] gnt;
    logic [N-1:0] done;
    logic err;
    logic [7:0] TDR;
    logic tdr_load;
    logic [2:0] sel;
    logic [1:0] owner;
    logic arb_busy;
    int n_chk = 0;
    int n_fail = 0;
    int m_owner = N - 1;
    logic [2:0] m_sel = 3'd0;

    uart_tx_scheduler #(.N_REQ(N), .SETTLE_CYCLES(S), .GAP_CYCLES(G), .BUSY_TO(B)) dut (
        .sysclk(sysclk), .rst(rst), .req(req), .req_data(req_data), .req_sel(req_sel),
        .gnt(gnt), .done(done), .err(err), .TDR(TDR), .tdr_load(tdr_load), .sel(sel),
        .txd_busy(txd_busy), .owner(owner), .arb_busy(arb_busy)
    );

    always #5 sysclk = ~sysclk;

    initial begin
        #500000;
        $display("FAIL watchdog: observed no end of test, expected completion");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge sysclk);
    endtask

    function automatic int rr_pick(input logic [N-1:0] r, input int own);
        for (int k = 1; k <= N; k++)
            if (r[(own + k) % N]) return (own + k) % N;
        return -1;
    endfunction

    task automatic chk_reset();
        chk("rst_gnt", gnt, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        chk("rst_load", tdr_load, 0);
        chk("rst_tdr", TDR, 0);
        chk("rst_sel", sel, 0);
        chk("rst_owner", owner, N - 1);
        chk("rst_arb_busy", arb_busy, 0);
    endtask

    // One complete frame starting from an IDLE decision on the next edge; ends on the first IDLE cycle after the gap.
    task automatic run_frame(input bit tmo, input int bdelay, input int blen, input logic [N-1:0] late_req);
        int w;
        int t;
        logic [7:0] nd;
        logic [2:0] nsel;
        bit chg;
        w = rr_pick(req, m_owner);
        nd = req_data[8*w +: 8];
        nsel = req_sel[3*w +: 3];
        chg = nsel != m_sel;
        tick();
        chk("gnt", gnt, 1 << w);
        chk("owner", owner, w);
        chk("tdr_grant", TDR, nd);
        chk("sel_at_grant", sel, m_sel);
        t = 0;
        do begin
            tick();
            t++;
            if (t == 1) chk("gnt_pulse", gnt, 0);
        end while (!tdr_load && t < 40);
        chk("load_latency", t, chg ? 2 + S : 2);
        chk("sel_at_load", sel, nsel);
        chk("tdr_at_load", TDR, nd);
        m_owner = w;
        m_sel = nsel;
        if (tmo) begin
            t = 0;
            do begin
                tick();
                t++;
            end while (done == 0 && t < B + 10);
            chk("timeout_latency", t, B);
            chk("timeout_done", done, 1 << w);
            chk("timeout_err", err, 1);
        end else begin
            repeat (bdelay) begin
                tick();
                chk("load_single", tdr_load, 0);
                chk("no_early_done", done, 0);
            end
            txd_busy = 1'b1;
            for (int i = 0; i < blen; i++) begin
                tick();
                if (i == 0 && late_req != 0) req = late_req;
                chk("sel_while_busy", sel, nsel);
                chk("no_done_busy", done, 0);
            end
            txd_busy = 1'b0;
            tick();
            chk("done", done, 1 << w);
            chk("done_err", err, 0);
        end
        chk("tdr_held", TDR, nd);
        t = 0;
        do begin
            tick();
            t++;
            chk("no_gnt_in_gap", gnt, 0);
        end while (arb_busy && t < G + 10);
        chk("gap_length", t, G + 1);
    endtask

    initial begin
        int t;
        repeat (3) tick();
        chk_reset();
        // Single request, no settle needed
        rst = 1'b0;
        req = 4'b0001;
        req_data[7:0] = 8'hA5;
        run_frame(1'b0, 2, 4, '0);
        // Round-robin with every client requesting
        req = 4'b1111;
        req_data = {8'h13, 8'h12, 8'h11, 8'h10};
        for (int i = 0; i < 4; i++) run_frame(1'b0, $urandom_range(1, B - 3), $urandom_range(1, 6), '0);
        // Baud select changes
        req = 4'b1110;
        req_sel[5:3] = 3'd3;
        req_sel[8:6] = 3'd3;
        req_sel[11:9] = 3'd5;
        for (int i = 0; i < 3; i++) run_frame(1'b0, $urandom_range(1, B - 3), $urandom_range(1, 6), '0);
        // Busy timeout
        req = 4'b0001;
        run_frame(1'b1, 0, 0, '0);
        // Reset in the middle of a frame
        req = 4'b0001;
        tick();
        t = 0;
        do begin
            tick();
            t++;
        end while (!tdr_load && t < 40);
        chk("rst_setup_load", tdr_load, 1);
        txd_busy = 1'b1;
        repeat (2) tick();
        rst = 1'b1;
        txd_busy = 1'b0;
        tick();
        chk_reset();
        repeat (3) begin
            tick();
            chk("rst_no_done", done, 0);
        end
        rst = 1'b0;
        req = 4'b0110;
        m_owner = N - 1;
        m_sel = 3'd0;
        run_frame(1'b0, 2, 3, '0);
        // Late request raised during WAIT_DONE
        req = 4'b0001;
        run_frame(1'b0, 3, 4, 4'b0100);
        run_frame(1'b0, 2, 2, '0);
        // Random frames
        for (int i = 0; i < 12; i++) begin
            req = N'($urandom_range(1, (1 << N) - 1));
            req_data = $urandom;
            for (int j = 0; j < N; j++) req_sel[3*j +: 3] = 3'($urandom_range(0, 3));
            run_frame($urandom_range(0, 4) == 0, $urandom_range(1, B - 3), $urandom_range(1, 8), '0);
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
